posit_operand_decode: RTL and testbench

POSIT_OPERAND_DECODE -- requirements
Module: posit_operand_decode

---
 rtl/posit_pkg.sv | 34 +++
 rtl/posit_operand_decode_if.sv | 43 ++++
 rtl/posit_field_extract.sv | 61 ++++++
 rtl/posit_operand_decode.sv | 134 +++++++++++++
 tb/tb_posit_operand_decode.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/posit_pkg.sv
// Shared posit definitions for the operand decode slice.
//   DefaultN / DefaultEs : default posit word and exponent field widths
//   rs_w / fw_w / sw_w   : regime-count, max-fraction and scale widths
//   posit_fields_t       : decoded operand at the default widths
package posit_pkg;

  localparam int unsigned DefaultN  = 32;
  localparam int unsigned DefaultEs = 4;

  function automatic int unsigned rs_w(input int unsigned n);
    return $clog2(n);
  endfunction

  // Sign plus the shortest regime (two bits) leave n-3 bits for exponent and fraction.
  function automatic int unsigned fw_w(input int unsigned n, input int unsigned es);
    return n - 3 - es;
  endfunction

  function automatic int unsigned sw_w(input int unsigned n, input int unsigned es);
    return rs_w(n) + 1 + es;
  endfunction

  localparam int unsigned DefaultFw = fw_w(DefaultN, DefaultEs);
  localparam int unsigned DefaultSw = sw_w(DefaultN, DefaultEs);

  typedef struct packed {
    logic                        sign;
    logic                        zero;
    logic                        nar;
    logic signed [DefaultSw-1:0] scale;
    logic [DefaultFw:0]          frac;
  } posit_fields_t;

endpackage

// File: rtl/posit_operand_decode_if.sv
// Operand-pair bus of the posit decoder.
//   IN1/IN2, in_valid, in_ready          : upstream operand pair handshake
//   A_*/B_* fields, out_valid, out_ready : downstream decoded pair handshake
//   slave modport  : decoder view
//   master modport : producer/consumer view
interface posit_operand_decode_if #(
  parameter int unsigned N  = posit_pkg::DefaultN,
  parameter int unsigned ES = posit_pkg::DefaultEs
) ();

  localparam int unsigned FW = posit_pkg::fw_w(N, ES);
  localparam int unsigned SW = posit_pkg::sw_w(N, ES);

  logic [N-1:0]         IN1;
  logic [N-1:0]         IN2;
  logic                 in_valid;
  logic                 in_ready;
  logic                 A_sign;
  logic                 B_sign;
  logic signed [SW-1:0] A_scale;
  logic signed [SW-1:0] B_scale;
  logic [FW:0]          A_frac;
  logic [FW:0]          B_frac;
  logic                 A_zero;
  logic                 B_zero;
  logic                 A_nar;
  logic                 B_nar;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  IN1, IN2, in_valid, out_ready,
    output in_ready, A_sign, B_sign, A_scale, B_scale, A_frac, B_frac,
           A_zero, B_zero, A_nar, B_nar, out_valid
  );

  modport master (
    output IN1, IN2, in_valid, out_ready,
    input  in_ready, A_sign, B_sign, A_scale, B_scale, A_frac, B_frac,
           A_zero, B_zero, A_nar, B_nar, out_valid
  );

endinterface

// File: rtl/posit_field_extract.sv
// Combinational per-operand posit field extraction, split in two halves that
// sit on either side of the first pipeline register.
//   Front half: operand_i -> sign/zero/nar flags, magnitude body, regime run and polarity
//   Back half : registered body/run/polarity/special -> scale (k*2^ES + e) and frac
module posit_field_extract
  import posit_pkg::*;
#(
  parameter int unsigned N    = DefaultN,
  parameter int unsigned ES   = DefaultEs,
  localparam int unsigned RS  = rs_w(N),
  localparam int unsigned FW  = fw_w(N, ES),
  localparam int unsigned SW  = sw_w(N, ES)
) (
  input  logic [N-1:0]         operand_i,
  output logic                 sign_o,
  output logic                 zero_o,
  output logic                 nar_o,
  output logic [N-4:0]         body_o,
  output logic [RS-1:0]        run_o,
  output logic                 pol_o,
  input  logic [N-4:0]         body_i,
  input  logic [RS-1:0]        run_i,
  input  logic                 pol_i,
  input  logic                 special_i,
  output logic signed [SW-1:0] scale_o,
  output logic [FW:0]          frac_o
);

  logic [N-2:0] mag;
  logic [N-2:0] diff;
  logic [N-4:0] rem;
  logic [RS:0]  k;

  assign sign_o = operand_i[N-1];
  assign zero_o = (operand_i == '0);
  assign nar_o  = operand_i[N-1] && (operand_i[N-2:0] == '0);

  // Low N-1 bits of the two's complement only depend on the low N-1 input bits.
  assign mag    = operand_i[N-1] ? (-operand_i[N-2:0]) : operand_i[N-2:0];
  assign pol_o  = mag[N-2];
  // Run >= 1 always consumes mag[N-2] and the terminator, so only N-3 bits can survive.
  assign body_o = mag[N-4:0];

  // Regime run length is the count of leading zeros of diff.
  assign diff = mag ^ {(N-1){mag[N-2]}};

  always_comb begin
    run_o = RS'(N - 1);
    for (int i = 0; i < N - 1; i++) begin
      if (diff[i]) run_o = RS'(N - 2 - i);
    end
  end

  assign k   = pol_i ? ({1'b0, run_i} - (RS+1)'(1)) : -{1'b0, run_i};
  // Drops the remaining regime bits and terminator; exponent bits cut off come in as zeros.
  assign rem = body_i << (run_i - RS'(1));

  assign scale_o = special_i ? '0 : {k, rem[N-4 -: ES]};
  assign frac_o  = special_i ? '0 : {1'b1, rem[FW-1:0]};

endmodule

// File: rtl/posit_operand_decode.sv
// Two-stage posit operand-pair decoder feeding a posit multiplier.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, flushes both stages
//   bus : slave side of posit_operand_decode_if (IN1/IN2 in, A_*/B_* fields out)
// Stage 1 holds flags, magnitude body and regime run; stage 2 holds scale/frac.
module posit_operand_decode
  import posit_pkg::*;
#(
  parameter int unsigned N  = DefaultN,
  parameter int unsigned ES = DefaultEs
) (
  input logic                   clk,
  input logic                   rst,
  posit_operand_decode_if.slave bus
);

  localparam int unsigned RS = rs_w(N);
  localparam int unsigned FW = fw_w(N, ES);
  localparam int unsigned SW = sw_w(N, ES);

  logic v1_q, v2_q;
  logic en1, en2;

  logic [N-1:0]         opnd      [2];
  logic                 f_sign    [2];
  logic                 f_zero    [2];
  logic                 f_nar     [2];
  logic [N-4:0]         f_body    [2];
  logic [RS-1:0]        f_run     [2];
  logic                 f_pol     [2];
  logic signed [SW-1:0] x_scale   [2];
  logic [FW:0]          x_frac    [2];

  logic                 s1_sign_q [2];
  logic                 s1_zero_q [2];
  logic                 s1_nar_q  [2];
  logic [N-4:0]         s1_body_q [2];
  logic [RS-1:0]        s1_run_q  [2];
  logic                 s1_pol_q  [2];

  logic                 o_sign_q  [2];
  logic                 o_zero_q  [2];
  logic                 o_nar_q   [2];
  logic signed [SW-1:0] o_scale_q [2];
  logic [FW:0]          o_frac_q  [2];

  assign opnd[0] = bus.IN1;
  assign opnd[1] = bus.IN2;

  // Each stage advances when it is empty or the stage after it advances.
  assign en2          = !v2_q || bus.out_ready;
  assign en1          = !v1_q || en2;
  assign bus.in_ready = en1;

  for (genvar g = 0; g < 2; g++) begin : g_opnd
    posit_field_extract #(
      .N (N),
      .ES(ES)
    ) u_extract (
      .operand_i(opnd[g]),
      .sign_o   (f_sign[g]),
      .zero_o   (f_zero[g]),
      .nar_o    (f_nar[g]),
      .body_o   (f_body[g]),
      .run_o    (f_run[g]),
      .pol_o    (f_pol[g]),
      .body_i   (s1_body_q[g]),
      .run_i    (s1_run_q[g]),
      .pol_i    (s1_pol_q[g]),
      .special_i(s1_zero_q[g] || s1_nar_q[g]),
      .scale_o  (x_scale[g]),
      .frac_o   (x_frac[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        s1_sign_q[i] <= 1'b0;
        s1_zero_q[i] <= 1'b0;
        s1_nar_q[i]  <= 1'b0;
        s1_body_q[i] <= '0;
        s1_run_q[i]  <= '0;
        s1_pol_q[i]  <= 1'b0;
        o_sign_q[i]  <= 1'b0;
        o_zero_q[i]  <= 1'b0;
        o_nar_q[i]   <= 1'b0;
        o_scale_q[i] <= '0;
        o_frac_q[i]  <= '0;
      end
    end else begin
      if (en1) begin
        v1_q <= bus.in_valid;
        if (bus.in_valid) begin
          for (int i = 0; i < 2; i++) begin
            s1_sign_q[i] <= f_sign[i];
            s1_zero_q[i] <= f_zero[i];
            s1_nar_q[i]  <= f_nar[i];
            s1_body_q[i] <= f_body[i];
            s1_run_q[i]  <= f_run[i];
            s1_pol_q[i]  <= f_pol[i];
          end
        end
      end
      if (en2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          for (int i = 0; i < 2; i++) begin
            o_sign_q[i]  <= s1_sign_q[i];
            o_zero_q[i]  <= s1_zero_q[i];
            o_nar_q[i]   <= s1_nar_q[i];
            o_scale_q[i] <= x_scale[i];
            o_frac_q[i]  <= x_frac[i];
          end
        end
      end
    end
  end

  assign bus.out_valid = v2_q;
  assign bus.A_sign    = o_sign_q[0];
  assign bus.A_zero    = o_zero_q[0];
  assign bus.A_nar     = o_nar_q[0];
  assign bus.A_scale   = o_scale_q[0];
  assign bus.A_frac    = o_frac_q[0];
  assign bus.B_sign    = o_sign_q[1];
  assign bus.B_zero    = o_zero_q[1];
  assign bus.B_nar     = o_nar_q[1];
  assign bus.B_scale   = o_scale_q[1];
  assign bus.B_frac    = o_frac_q[1];

endmodule

// File: tb/tb_posit_operand_decode.sv
// Self-checking bench for posit_operand_decode at N=32, ES=4.
module tb_posit_operand_decode;
  import posit_pkg::*;

  localparam int unsigned N  = DefaultN;
  localparam int unsigned ES = DefaultEs;
  localparam int unsigned FW = DefaultFw;
  localparam int unsigned SW = DefaultSw;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  posit_operand_decode_if #(.N(N), .ES(ES)) bus ();

  posit_operand_decode #(
    .N (N),
    .ES(ES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [N-1:0]  in1;
    logic [N-1:0]  in2;
    posit_fields_t exp_a;
    posit_fields_t exp_b;
  } vec_t;

  vec_t vecs [7];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic posit_fields_t mk(input logic s, input logic z, input logic na,
                                       input int scale, input logic [FW:0] frac);
    posit_fields_t f;
    f.sign  = s;
    f.zero  = z;
    f.nar   = na;
    f.scale = SW'(scale);
    f.frac  = frac;
    return f;
  endfunction

  function automatic posit_fields_t get_a();
    posit_fields_t f;
    f.sign  = bus.A_sign;
    f.zero  = bus.A_zero;
    f.nar   = bus.A_nar;
    f.scale = bus.A_scale;
    f.frac  = bus.A_frac;
    return f;
  endfunction

  function automatic posit_fields_t get_b();
    posit_fields_t f;
    f.sign  = bus.B_sign;
    f.zero  = bus.B_zero;
    f.nar   = bus.B_nar;
    f.scale = bus.B_scale;
    f.frac  = bus.B_frac;
    return f;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // One pair through an idle pipe: accept at edge t, valid in cycle t+2.
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    bus.IN1       = v.in1;
    bus.IN2       = v.in2;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1 check($sformatf("vec%0d_in_ready", idx), 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check($sformatf("vec%0d_valid_t1", idx), 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    #1 check($sformatf("vec%0d_valid_t2", idx), 64'(bus.out_valid), 64'd1);
    check($sformatf("vec%0d_A", idx), 64'(get_a()), 64'(v.exp_a));
    check($sformatf("vec%0d_B", idx), 64'(get_b()), 64'(v.exp_b));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    posit_fields_t exp_qa[$];
    posit_fields_t exp_qb[$];
    posit_fields_t held_a, held_b;
    posit_fields_t ea, eb;
    logic          held;
    int            sent, got, seen;

    vecs[0] = '{32'h4000_0000, 32'hC000_0000,
                mk(1'b0, 1'b0, 1'b0, 0, 26'h200_0000), mk(1'b1, 1'b0, 1'b0, 0, 26'h200_0000)};
    vecs[1] = '{32'h4CD0_CCCD, 32'hB32F_3333,
                mk(1'b0, 1'b0, 1'b0, 6, 26'h2D0_CCCD), mk(1'b1, 1'b0, 1'b0, 6, 26'h2D0_CCCD)};
    vecs[2] = '{32'h8000_0000, 32'h0000_0000,
                mk(1'b1, 1'b0, 1'b1, 0, 26'h0), mk(1'b0, 1'b1, 1'b0, 0, 26'h0)};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001,
                mk(1'b0, 1'b0, 1'b0, 480, 26'h200_0000), mk(1'b0, 1'b0, 1'b0, -480, 26'h200_0000)};
    vecs[4] = '{32'h0000_0000, 32'h7123_4567,
                mk(1'b0, 1'b1, 1'b0, 0, 26'h0), mk(1'b0, 1'b0, 1'b0, 34, 26'h28D_159C)};
    vecs[5] = '{32'h0C00_0000, 32'h8000_0000,
                mk(1'b0, 1'b0, 1'b0, -40, 26'h200_0000), mk(1'b1, 1'b0, 1'b1, 0, 26'h0)};
    vecs[6] = '{32'h8000_0001, 32'h0000_0003,
                mk(1'b1, 1'b0, 1'b0, 480, 26'h200_0000), mk(1'b0, 1'b0, 1'b0, -456, 26'h200_0000)};

    bus.IN1       = '0;
    bus.IN2       = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_A_fields", 64'(get_a()), 64'd0);
    check("rst_B_fields", 64'(get_b()), 64'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Back-to-back stream of 8 pairs with a 3-cycle downstream stall
    sent = 0;
    got  = 0;
    held = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 4 && cyc <= 6);
      bus.in_valid  = (sent < 8);
      if (sent < 8) begin
        bus.IN1 = vecs[sent % 7].in1;
        bus.IN2 = vecs[(sent + 3) % 7].in2;
      end
      #1;
      if (!bus.out_ready) check("stream_in_ready_stall", 64'(bus.in_ready), 64'd0);
      if (bus.out_valid) begin
        if (held) begin
          check("stream_stable_A", 64'(get_a()), 64'(held_a));
          check("stream_stable_B", 64'(get_b()), 64'(held_b));
        end
        if (bus.out_ready) begin
          if (exp_qa.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL stream_extra: output with no pair outstanding, got A=0x%0h", get_a());
          end else begin
            ea = exp_qa.pop_front();
            eb = exp_qb.pop_front();
            check($sformatf("stream%0d_A", got), 64'(get_a()), 64'(ea));
            check($sformatf("stream%0d_B", got), 64'(get_b()), 64'(eb));
          end
          got++;
          held = 1'b0;
        end else begin
          held   = 1'b1;
          held_a = get_a();
          held_b = get_b();
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_qa.push_back(vecs[sent % 7].exp_a);
        exp_qb.push_back(vecs[(sent + 3) % 7].exp_b);
        sent++;
      end
    end
    check("stream_count", 64'(got), 64'd8);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Stall fill-up, then reset with two pairs in flight
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.IN1       = vecs[0].in1;
    bus.IN2       = vecs[0].in2;
    bus.in_valid  = 1'b1;
    #1 check("hold_accept_p0", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("hold_out_valid", 64'(bus.out_valid), 64'd1);
    check("hold_one_more", 64'(bus.in_ready), 64'd1);
    bus.IN1      = vecs[1].in1;
    bus.IN2      = vecs[1].in2;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.IN1 = vecs[2].in1;
    bus.IN2 = vecs[2].in2;
    #1;
    check("hold_full_in_ready", 64'(bus.in_ready), 64'd0);
    check("hold_A_p0", 64'(get_a()), 64'(vecs[0].exp_a));
    check("hold_B_p0", 64'(get_b()), 64'(vecs[0].exp_b));
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("midrst_out_valid_async", 64'(bus.out_valid), 64'd0);
    check("midrst_A_cleared", 64'(get_a()), 64'd0);
    @(negedge clk);
    check("midrst_out_valid_edge", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      #1 if (bus.out_valid) seen++;
    end
    check("midrst_no_stale", 64'(seen), 64'd0);

    run_vec(vecs[3], 7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
